// File: rtl/regfister_file.sv
// regfister_file: small one-hot addressed register bank.
// Single write bus, single OR-combined read port.
module regfister_file #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [WIDTH-1:0] A,
  input  logic             RegCE,
  input  logic [NREGS-1:0] RegNum,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] regs [NREGS];
  logic [NREGS-1:0] wr_en;

  // per-register write strobe from global enable and one-hot select
  always_comb begin
    wr_en = '0;
    if (RegCE) wr_en = RegNum;
  end

  // each register: sync clear, else clock-enabled load from A
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREGS; i++) begin
      if (nReset) begin
        regs[i] <= '0;
      end else if (wr_en[i]) begin
        regs[i] <= A;
      end
    end
  end

  // read: OR of every selected register, no bypass from A
  always_comb begin
    out = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (RegNum[i]) out = out | regs[i];
    end
  end

endmodule

// File: tb/tb_regfister_file.sv
// tb_regfister_file: vector table plus random run
// against an array model of the register bank.
module tb_regfister_file;

  logic       clk = 1'b0;
  logic       nReset;
  logic [7:0] A;
  logic       RegCE;
  logic [3:0] RegNum;
  logic [7:0] out;

  int total = 0;
  int bad   = 0;

  logic [7:0] m [4];

  typedef struct {
    logic       rst;
    logic       ce;
    logic [3:0] num;
    logic [7:0] a;
    logic [3:0] rd;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl [$];

  regfister_file #(.WIDTH(8), .NREGS(4)) dut (
    .clk    (clk),
    .nReset (nReset),
    .A      (A),
    .RegCE  (RegCE),
    .RegNum (RegNum),
    .out    (out)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] mread(logic [3:0] sel);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 4; i++)
      if (sel[i]) r = r | m[i];
    return r;
  endfunction

  function automatic void mwrite(logic rst, logic ce,
                                 logic [3:0] sel,
                                 logic [7:0] d);
    for (int i = 0; i < 4; i++) begin
      if (rst) m[i] = 8'h00;
      else if (ce && sel[i]) m[i] = d;
    end
  endfunction

  task automatic chk(string name, logic [7:0] act,
                     logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: out=%h expected=%h", name, act, exp);
    end
  endtask

  // drive one edge, check no-bypass before it
  // and the read-back after it
  task automatic apply(logic rst, logic ce,
                       logic [3:0] num, logic [7:0] a,
                       logic [3:0] rd, string name);
    nReset = rst;
    RegCE  = ce;
    RegNum = num;
    A      = a;
    #1;
    chk({name, "_pre"}, out, mread(num));
    @(posedge clk);
    mwrite(rst, ce, num, a);
    #1;
    nReset = 1'b0;
    RegCE  = 1'b0;
    RegNum = rd;
    #1;
    chk({name, "_post"}, out, mread(rd));
  endtask

  initial begin
    nReset = 1'b1;
    RegCE  = 1'b0;
    RegNum = 4'b1111;
    A      = 8'h00;
    @(posedge clk);
    mwrite(1'b1, 1'b0, 4'h0, 8'h00);
    #1;
    chk("reset_all", out, 8'h00);

    // preload, reset, readback
    tbl.push_back('{0, 1, 4'b0001, 8'h11, 4'b0001, 8'h11});
    tbl.push_back('{0, 1, 4'b0010, 8'h22, 4'b0010, 8'h22});
    tbl.push_back('{0, 1, 4'b0100, 8'h33, 4'b0100, 8'h33});
    tbl.push_back('{0, 1, 4'b1000, 8'h44, 4'b1000, 8'h44});
    tbl.push_back('{1, 1, 4'b1111, 8'h99, 4'b0001, 8'h00});
    tbl.push_back('{0, 0, 4'b0010, 8'hEE, 4'b0010, 8'h00});
    tbl.push_back('{0, 0, 4'b0100, 8'hEE, 4'b0100, 8'h00});
    tbl.push_back('{0, 0, 4'b1000, 8'hEE, 4'b1000, 8'h00});
    // sequential writes
    tbl.push_back('{0, 1, 4'b0001, 8'h04, 4'b0001, 8'h04});
    tbl.push_back('{0, 1, 4'b0010, 8'h05, 4'b0010, 8'h05});
    tbl.push_back('{0, 1, 4'b0100, 8'h06, 4'b0100, 8'h06});
    tbl.push_back('{0, 1, 4'b1000, 8'h07, 4'b1000, 8'h07});
    // write enable gating
    tbl.push_back('{0, 0, 4'b0010, 8'hAA, 4'b0010, 8'h05});
    tbl.push_back('{0, 0, 4'b0010, 8'hAA, 4'b0010, 8'h05});
    tbl.push_back('{0, 0, 4'b0010, 8'hAA, 4'b0010, 8'h05});
    // zero select
    tbl.push_back('{0, 1, 4'b0000, 8'hFF, 4'b0000, 8'h00});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b0001, 8'h04});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b0010, 8'h05});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b0100, 8'h06});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b1000, 8'h07});
    // multi-hot
    tbl.push_back('{0, 1, 4'b0101, 8'h3C, 4'b0011, 8'h3D});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b0100, 8'h3C});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b1000, 8'h07});
    tbl.push_back('{0, 0, 4'b0000, 8'h00, 4'b0010, 8'h05});
    // reset/write collision
    tbl.push_back('{1, 1, 4'b1000, 8'h55, 4'b1000, 8'h00});
    tbl.push_back('{0, 1, 4'b1000, 8'h55, 4'b1000, 8'h55});

    foreach (tbl[k]) begin
      apply(tbl[k].rst, tbl[k].ce, tbl[k].num,
            tbl[k].a, tbl[k].rd, $sformatf("vec%0d", k));
      chk($sformatf("vec%0d_tbl", k), out, tbl[k].exp);
    end

    // held write: value appears only after its edge
    nReset = 1'b0;
    RegCE  = 1'b1;
    RegNum = 4'b0001;
    A      = 8'h77;
    #1;
    chk("nobypass", out, 8'h00);
    @(posedge clk);
    #1;
    chk("after_edge", out, 8'h77);
    m[0] = 8'h77;
    RegCE = 1'b0;

    for (int k = 0; k < 400; k++) begin
      apply(($urandom_range(0, 15) == 0),
            1'($urandom_range(0, 1)),
            4'($urandom_range(0, 15)),
            8'($urandom_range(0, 255)),
            4'($urandom_range(0, 15)),
            $sformatf("rnd%0d", k));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfister_file.md
# regfister_file

Small general-purpose register bank for the datapath: four 8-bit registers, written from a single data bus and read through a single output port. Each register is a clock-enabled parallel-in/parallel-out flop stage. A one-hot register select chooses the written and read registers. A global write enable gates all writes. It sits between the ALU/accumulator result bus (`A`) and the operand path that consumes `out`.

## Interface
Parameters:
- `WIDTH`, default 8: data width of each register, `A` and `out`.
- `NREGS`, default 4: number of registers; also the width of `RegNum`.

Ports:
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `nReset`, input, 1: reset, synchronous and active-high. Asserted (1) clears all registers at the next rising edge. The name is kept for codebase consistency; the polarity is high.
- `A`, input, WIDTH: write data.
- `RegCE`, input, 1: global write enable, active-high.
- `RegNum`, input, NREGS: one-hot register select; bit i selects register i.
- `out`, output, WIDTH: read data for the selected register(s).

## Operation
- State: `reg[0..NREGS-1]`, each WIDTH bits.
- Write at the rising edge of `clk`, for each i:
  - if `nReset`=1: `reg[i]` <= 0;
  - else if `RegCE`=1 and `RegNum[i]`=1: `reg[i]` <= `A`;
  - else `reg[i]` holds.
- Reset has priority over write; `RegCE`/`RegNum`/`A` are ignored while `nReset`=1.
- Read is combinational from current register contents: `out` = bitwise OR over i of (`RegNum[i]` ? `reg[i]` : 0).
  - Exactly one bit set: `out` = that register.
  - `RegNum`=0: `out`=0, no register written.
  - Multi-hot `RegNum`: every selected register is written with `A`; `out` = OR of selected registers. This is legal and defined, not an error.
- Write-then-read: `out` shows the newly written value after the write edge, not in the same cycle. There is no write-through bypass from `A` to `out`.
- `RegCE`=0: no writes; read path unaffected.
- No X-propagation requirements beyond standard RTL. Registers are undefined until the first reset edge.

## Timing
- Write latency: 1 clock edge from `A`/`RegNum`/`RegCE` to register update.
- Read latency: 0 cycles (combinational through the select mux) from `RegNum` or register change to `out`.
- Reset: synchronous. After the first rising edge with `nReset`=1, all registers = 0 and `out` = 0 for any `RegNum`.
- Reset mid-operation: a write presented on the same edge as reset is discarded; registers = 0.
- Releasing reset (`nReset` 1→0): writes resume at the first edge where `nReset`=0.
- Inputs must be stable around the rising `clk` edge (single clock domain, no CDC logic).
- `out` is reset value 0 and is not separately registered.

## Test plan
- Reset: load all registers with non-zero values, assert `nReset`=1 for one edge → every register reads 0 for `RegNum`=0001, 0010, 0100 and 1000.
- Sequential writes: with `nReset`=0 and `RegCE`=1, write 4, 5, 6 and 7 to `RegNum`=0001, 0010, 0100 and 1000 on consecutive edges, then set `RegCE`=0 and read each → `out`=4, 5, 6, 7 respectively. Each value appears on `out` only after its write edge.
- Write enable gating: set `RegCE`=0, `RegNum`=0010, `A`=8'hAA, for several edges → register 1 keeps 5 and `out`=5.
- Zero select: set `RegNum`=0000, `RegCE`=1, `A`=8'hFF → no register changes and `out`=0. Reading back shows 4, 5, 6, 7 unchanged.
- Multi-hot: set `RegNum`=0101, `RegCE`=1, `A`=8'h3C, one edge → registers 0 and 2 = 8'h3C, registers 1 and 3 unchanged. Then `RegNum`=0011 → `out` = 8'h3C | register 1.
- Reset/write collision: with `nReset`=1, `RegCE`=1, `RegNum`=1000, `A`=8'h55 on the same edge → register 3 = 0. The next edge with `nReset`=0 writes 8'h55.
